// File: rtl/popcount25_thermo_gen.sv
// Count-to-thermometer generator: turns a count into an N-bit LSB-first thermometer word,
// presented both as a registered parallel vector and as an N-beat valid/ready serial frame.
module popcount25_thermo_gen #(
  parameter int N  = 25,
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [CW-1:0] in_count,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          out_bit,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic [N-1:0]  out_vec,
  output logic          out_vec_stb,
  output logic          sat_flag
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] idx, idx_nxt;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_sat;
  logic          take;

  function automatic logic [CW-1:0] clamp_count(input logic [CW-1:0] c);
    return (c > CW'(N)) ? CW'(N) : c;
  endfunction

  function automatic logic [N-1:0] thermo(input logic [CW-1:0] c);
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = (CW'(i) < c);
    return v;
  endfunction

  assign cnt_sat = clamp_count(in_count);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // A transfer on the last-beat handshake overrides the return to IDLE, giving gapless frames.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    out_valid = 1'b0;
    out_bit   = 1'b0;
    out_last  = 1'b0;
    in_ready  = 1'b0;
    case (state)
      IDLE: in_ready = 1'b1;
      EMIT: begin
        out_valid = 1'b1;
        out_bit   = (idx < cnt_r);
        out_last  = (idx == CW'(N - 1));
        in_ready  = out_ready && out_last;
        if (out_ready) begin
          if (out_last) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
          end else begin
            idx_nxt = idx + CW'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    take = in_valid && in_ready;
    if (take) begin
      state_nxt = EMIT;
      idx_nxt   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx         <= '0;
      cnt_r       <= '0;
      out_vec     <= '0;
      out_vec_stb <= 1'b0;
      sat_flag    <= 1'b0;
    end else begin
      idx         <= idx_nxt;
      out_vec_stb <= take;
      if (take) begin
        cnt_r    <= cnt_sat;
        sat_flag <= (in_count > CW'(N));
        out_vec  <= thermo(cnt_sat);
      end
    end
  end

endmodule
